// File: rtl/cpu_pkg.sv
// Shared opcode, shift and instruction-field definitions for the 8-bit CPU.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_MOV = 4'h2,
    OP_ADD = 4'h3,
    OP_ADC = 4'h4,
    OP_SUB = 4'h5,
    OP_SBC = 4'h6,
    OP_AND = 4'h7,
    OP_OR  = 4'h8,
    OP_XOR = 4'h9,
    OP_CMP = 4'hA,
    OP_SHF = 4'hB,
    OP_SPH = 4'hC,
    OP_OUT = 4'hD,
    OP_IN  = 4'hE,
    OP_JMP = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    SHF_SHL = 2'd0,
    SHF_SHR = 2'd1,
    SHF_ROL = 2'd2,
    SHF_ROR = 2'd3
  } shf_t;

  // PSW bit positions
  localparam int unsigned PSW_C = 0;
  localparam int unsigned PSW_Z = 1;
  localparam int unsigned PSW_N = 2;
  localparam int unsigned PSW_V = 3;

  // Instruction word field positions
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 9;
  localparam int unsigned I_BIT   = 8;
  localparam int unsigned RS_MSB  = 2;
  localparam int unsigned RS_LSB  = 0;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU for ops ADD..SHF; for SHF the sub-op is carried in i_b[1:0].
module alu8
  import cpu_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_r,
  output logic       o_c,
  output logic       o_v,
  output logic       o_z,
  output logic       o_n
);

  opcode_t    w_op;
  shf_t       w_shf;
  logic [8:0] w_sum;
  logic [8:0] w_diff;

  assign w_op  = opcode_t'(i_op);
  assign w_shf = shf_t'(i_b[1:0]);

  // 9-bit add/subtract; bit 8 is carry (add) or borrow (subtract)
  always_comb begin
    w_sum  = {1'b0, i_a} + {1'b0, i_b} + 9'((w_op == OP_ADC) ? i_cin : 1'b0);
    w_diff = {1'b0, i_a} - {1'b0, i_b} - 9'((w_op == OP_SBC) ? i_cin : 1'b0);
  end

  // Result, carry and overflow selection by opcode
  always_comb begin
    o_r = i_b;
    o_c = i_cin;
    o_v = 1'b0;
    case (w_op)
      OP_ADD, OP_ADC: begin
        o_r = w_sum[7:0];
        o_c = w_sum[8];
        o_v = (i_a[7] == i_b[7]) && (w_sum[7] != i_a[7]);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        o_r = w_diff[7:0];
        o_c = w_diff[8];
        o_v = (i_a[7] != i_b[7]) && (w_diff[7] != i_a[7]);
      end
      OP_AND: o_r = i_a & i_b;
      OP_OR:  o_r = i_a | i_b;
      OP_XOR: o_r = i_a ^ i_b;
      OP_SHF: begin
        case (w_shf)
          SHF_SHL: begin o_r = {i_a[6:0], 1'b0};  o_c = i_a[7]; end
          SHF_SHR: begin o_r = {1'b0, i_a[7:1]};  o_c = i_a[0]; end
          SHF_ROL: begin o_r = {i_a[6:0], i_cin}; o_c = i_a[7]; end
          default: begin o_r = {i_cin, i_a[7:1]}; o_c = i_a[0]; end
        endcase
      end
      default: ;
    endcase
  end

  assign o_z = (o_r == 8'h00);
  assign o_n = o_r[7];

endmodule

// File: rtl/exec_stage.sv
// Execute stage: register file, ALU, PSW, page register and I/O port; one instruction per clock.
module exec_stage
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS     = 8,
  parameter logic [7:0]  PCH_RESET = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] PRG,
  input  logic [7:0]  PORT_IN,
  output logic [7:0]  PSW,
  output logic [7:0]  PCH,
  output logic [7:0]  PORT_OUT,
  output logic        PORT_STB
);

  localparam int unsigned IW       = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [2:0]  IDX_MASK = 3'(NREGS - 1);

  logic [7:0]    r_regs [NREGS];
  logic [3:0]    r_psw;
  logic [7:0]    r_pch;
  logic [7:0]    r_port_out;
  logic          r_port_stb;

  opcode_t       w_op;
  logic [IW-1:0] w_rd;
  logic [IW-1:0] w_rs;
  logic [7:0]    w_imm;
  logic [7:0]    w_a;
  logic [7:0]    w_b;
  logic [7:0]    w_alu_b;
  logic [7:0]    w_alu_r;
  logic          w_alu_c;
  logic          w_alu_v;
  logic          w_alu_z;
  logic          w_alu_n;
  logic          w_reg_we;
  logic [7:0]    w_reg_wdata;
  logic          w_psw_we;
  logic [3:0]    w_psw_next;

  // Instruction decode and operand fetch; register indices wrap modulo NREGS
  assign w_op    = opcode_t'(PRG[OP_MSB:OP_LSB]);
  assign w_rd    = IW'(PRG[RD_MSB:RD_LSB] & IDX_MASK);
  assign w_rs    = IW'(PRG[RS_MSB:RS_LSB] & IDX_MASK);
  assign w_imm   = PRG[IMM_MSB:IMM_LSB];
  assign w_a     = r_regs[w_rd];
  assign w_b     = PRG[I_BIT] ? w_imm : r_regs[w_rs];
  // SHF ignores I and takes its sub-op from the immediate field
  assign w_alu_b = (w_op == OP_SHF) ? w_imm : w_b;

  alu8 u_alu (
    .i_op  (PRG[OP_MSB:OP_LSB]),
    .i_a   (w_a),
    .i_b   (w_alu_b),
    .i_cin (r_psw[PSW_C]),
    .o_r   (w_alu_r),
    .o_c   (w_alu_c),
    .o_v   (w_alu_v),
    .o_z   (w_alu_z),
    .o_n   (w_alu_n)
  );

  // Write-back selection for the register file and PSW
  always_comb begin
    w_reg_we    = 1'b0;
    w_reg_wdata = w_alu_r;
    w_psw_we    = 1'b0;
    w_psw_next  = r_psw;
    w_psw_next[PSW_C] = w_alu_c;
    w_psw_next[PSW_Z] = w_alu_z;
    w_psw_next[PSW_N] = w_alu_n;
    w_psw_next[PSW_V] = w_alu_v;
    case (w_op)
      OP_LDI: begin w_reg_we = 1'b1; w_reg_wdata = w_imm; end
      OP_MOV: begin w_reg_we = 1'b1; w_reg_wdata = w_b; end
      OP_IN:  begin w_reg_we = 1'b1; w_reg_wdata = PORT_IN; end
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_XOR, OP_SHF: begin
        w_reg_we = 1'b1;
        w_psw_we = 1'b1;
      end
      OP_CMP: w_psw_we = 1'b1;
      default: ;
    endcase
  end

  // Architectural state update; reset wins over any instruction
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= 8'h00;
      r_psw      <= 4'h0;
      r_pch      <= PCH_RESET;
      r_port_out <= 8'h00;
      r_port_stb <= 1'b0;
    end else begin
      if (w_reg_we)        r_regs[w_rd] <= w_reg_wdata;
      if (w_psw_we)        r_psw        <= w_psw_next;
      if (w_op == OP_SPH)  r_pch        <= w_b;
      if (w_op == OP_OUT)  r_port_out   <= w_b;
      r_port_stb <= (w_op == OP_OUT);
    end
  end

  assign PSW      = {4'b0000, r_psw};
  assign PCH      = r_pch;
  assign PORT_OUT = r_port_out;
  assign PORT_STB = r_port_stb;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: directed sequences plus random instruction stream.
module tb_exec_stage;

  logic        CLK;
  logic        RESET;
  logic [15:0] PRG;
  logic [7:0]  PORT_IN;
  logic [7:0]  PSW;
  logic [7:0]  PCH;
  logic [7:0]  PORT_OUT;
  logic        PORT_STB;

  exec_stage #(.NREGS(8), .PCH_RESET(8'h00)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .PRG      (PRG),
    .PORT_IN  (PORT_IN),
    .PSW      (PSW),
    .PCH      (PCH),
    .PORT_OUT (PORT_OUT),
    .PORT_STB (PORT_STB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] psw;
    logic [7:0] pch;
    logic [7:0] pout;
    logic       stb;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  // reference model state
  int   m_regs[8];
  int   m_c, m_z, m_n, m_v;
  int   m_pch, m_pout, m_stb;

  function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [15:0] enc(int op, int rd, int i, int v);
    return {4'(op), 3'(rd), 1'(i), 8'(v)};
  endfunction

  function automatic int sx(int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Behavioural model of one retired instruction, straight from the ISA rules
  task automatic model_step(input logic rst, input logic [15:0] prg, input logic [7:0] pin);
    int op, rd, rs, i, imm, a, b, r, s, sv, sub;
    exp_t e;
    if (rst) begin
      foreach (m_regs[k]) m_regs[k] = 0;
      m_c = 0; m_z = 0; m_n = 0; m_v = 0;
      m_pch = 0; m_pout = 0; m_stb = 0;
    end else begin
      op  = int'(prg[15:12]);
      rd  = int'(prg[11:9]) % 8;
      rs  = int'(prg[2:0]) % 8;
      i   = int'(prg[8]);
      imm = int'(prg[7:0]);
      a   = m_regs[rd];
      b   = (i != 0) ? imm : m_regs[rs];
      r   = 0;
      case (op)
        1:  m_regs[rd] = imm;
        2:  m_regs[rd] = b;
        3, 4: begin
          sub = (op == 4) ? m_c : 0;
          s   = a + b + sub;
          sv  = sx(a) + sx(b) + sub;
          r   = s % 256;
          m_c = (s > 255) ? 1 : 0;
          m_v = (sv > 127 || sv < -128) ? 1 : 0;
        end
        5, 6, 10: begin
          sub = (op == 6) ? m_c : 0;
          s   = a - b - sub;
          sv  = sx(a) - sx(b) - sub;
          r   = (s + 512) % 256;
          m_c = (s < 0) ? 1 : 0;
          m_v = (sv > 127 || sv < -128) ? 1 : 0;
        end
        7:  begin r = a & b; m_v = 0; end
        8:  begin r = a | b; m_v = 0; end
        9:  begin r = a ^ b; m_v = 0; end
        11: begin
          m_v = 0;
          case (imm % 4)
            0: begin r = (a * 2) % 256;       m_c = a / 128; end
            1: begin r = a / 2;               m_c = a % 2;   end
            2: begin r = (a * 2 + m_c) % 256; m_c = a / 128; end
            default: begin r = a / 2 + m_c * 128; m_c = a % 2; end
          endcase
        end
        12: m_pch = b;
        13: m_pout = b;
        14: m_regs[rd] = int'(pin);
        default: ;
      endcase
      if (op >= 3 && op <= 11) begin
        m_z = (r == 0) ? 1 : 0;
        m_n = (r >= 128) ? 1 : 0;
        if (op != 10) m_regs[rd] = r;
      end
      m_stb = (op == 13) ? 1 : 0;
    end
    e.psw  = 8'(m_v * 8 + m_n * 4 + m_z * 2 + m_c);
    e.pch  = 8'(m_pch);
    e.pout = 8'(m_pout);
    e.stb  = 1'(m_stb);
    sb_q.push_back(e);
  endtask

  // Drive one instruction for the next edge and record its expected outcome
  task automatic step(input logic rst, input logic [15:0] prg, input logic [7:0] pin);
    @(negedge CLK);
    RESET   = rst;
    PRG     = prg;
    PORT_IN = pin;
    model_step(rst, prg, pin);
  endtask

  // Wait for the edge that retires the last driven instruction
  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  // Monitor: every edge with a pending expectation is checked
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("psw", PSW, e.psw);
        chk("pch", PCH, e.pch);
        chk("port_out", PORT_OUT, e.pout);
        chk("port_stb", {7'b0, PORT_STB}, {7'b0, e.stb});
      end
    end
  end

  initial begin
    RESET   = 1'b1;
    PRG     = 16'h0000;
    PORT_IN = 8'h00;

    // 1: reset then OUT r0
    step(1'b1, enc(0, 0, 0, 0), 8'h00);
    step(1'b1, enc(0, 0, 0, 0), 8'h00);
    step(1'b0, enc(13, 0, 0, 0), 8'h00);
    settle();
    chk("t1_port_out", PORT_OUT, 8'h00);
    chk("t1_psw", PSW, 8'h00);
    chk("t1_pch", PCH, 8'h00);
    chk("t1_stb_hi", {7'b0, PORT_STB}, 8'h01);
    step(1'b0, enc(0, 0, 0, 0), 8'h00);
    settle();
    chk("t1_stb_lo", {7'b0, PORT_STB}, 8'h00);

    // 2: FF+1 wraps with C,Z; LDI keeps PSW
    step(1'b0, enc(1, 1, 0, 8'hFF), 8'h00);
    step(1'b0, enc(3, 1, 1, 8'h01), 8'h00);
    settle();
    chk("t2_psw_add", PSW, 8'h03);
    step(1'b0, enc(1, 2, 0, 8'h55), 8'h00);
    step(1'b0, enc(13, 0, 0, 1), 8'h00);
    settle();
    chk("t2_psw_ldi", PSW, 8'h03);
    chk("t2_r1", PORT_OUT, 8'h00);

    // 3: signed overflow then ADC with C=0
    step(1'b0, enc(1, 2, 0, 8'h7F), 8'h00);
    step(1'b0, enc(3, 2, 1, 8'h01), 8'h00);
    settle();
    chk("t3_psw_add", PSW, 8'h0C);
    step(1'b0, enc(4, 2, 1, 8'h00), 8'h00);
    step(1'b0, enc(13, 0, 0, 2), 8'h00);
    settle();
    chk("t3_psw_adc", PSW, 8'h04);
    chk("t3_r2", PORT_OUT, 8'h80);

    // 4: CMP borrow, then SBC consumes it
    step(1'b0, enc(1, 3, 0, 8'h05), 8'h00);
    step(1'b0, enc(10, 3, 1, 8'h06), 8'h00);
    step(1'b0, enc(13, 0, 0, 3), 8'h00);
    settle();
    chk("t4_psw_cmp", PSW, 8'h05);
    chk("t4_r3_kept", PORT_OUT, 8'h05);
    step(1'b0, enc(6, 3, 1, 8'h00), 8'h00);
    step(1'b0, enc(13, 0, 0, 3), 8'h00);
    settle();
    chk("t4_r3_sbc", PORT_OUT, 8'h04);

    // 5: SPH, IN, OUT strobe
    step(1'b0, enc(12, 0, 1, 8'h12), 8'h00);
    settle();
    chk("t5_pch", PCH, 8'h12);
    chk("t5_psw", PSW, 8'h00);
    step(1'b0, enc(14, 4, 0, 0), 8'hA5);
    step(1'b0, enc(13, 0, 0, 4), 8'h00);
    settle();
    chk("t5_port_out", PORT_OUT, 8'hA5);
    chk("t5_stb_hi", {7'b0, PORT_STB}, 8'h01);
    step(1'b0, enc(0, 0, 0, 0), 8'h00);
    settle();
    chk("t5_stb_lo", {7'b0, PORT_STB}, 8'h00);

    // back-to-back OUT keeps the strobe high
    step(1'b0, enc(13, 0, 1, 8'h11), 8'h00);
    step(1'b0, enc(13, 0, 1, 8'h22), 8'h00);
    settle();
    chk("b2b_out", PORT_OUT, 8'h22);
    chk("b2b_stb", {7'b0, PORT_STB}, 8'h01);

    // 6: ROR through C, then reset beats ADD
    step(1'b0, enc(10, 3, 1, 8'h06), 8'h00);
    step(1'b0, enc(1, 5, 0, 8'h81), 8'h00);
    step(1'b0, enc(11, 5, 0, 3), 8'h00);
    step(1'b0, enc(13, 0, 0, 5), 8'h00);
    settle();
    chk("t6_r5_ror", PORT_OUT, 8'hC0);
    chk("t6_c", {7'b0, PSW[0]}, 8'h01);
    step(1'b0, enc(13, 0, 1, 8'h33), 8'h00);
    step(1'b1, enc(3, 5, 1, 8'h01), 8'h00);
    settle();
    chk("t6_rst_stb", {7'b0, PORT_STB}, 8'h00);
    chk("t6_rst_psw", PSW, 8'h00);
    step(1'b0, enc(13, 0, 0, 5), 8'h00);
    settle();
    chk("t6_r5_rst", PORT_OUT, 8'h00);

    // random instruction stream with occasional reset
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(63) == 0), 16'($urandom), 8'($urandom));
    end
    step(1'b0, enc(0, 0, 0, 0), 8'h00);

    repeat (2) @(posedge CLK);
    #3;
    chk("sb_drained", 8'(sb_q.size()), 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
